// File: rtl/pwm_ramp_scheduler.sv
// Ramp scheduler between the SPI command receiver and the PWM channel bank.
// Holds a target and a current compare value per channel. On every ramp tick
// it walks all channels once and moves each current value one step toward its
// target. Changed values go out on a shared compare bus with a one-hot strobe.
module pwm_ramp_scheduler #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned COMPARE_SIZE = 8,
  parameter int unsigned PERIOD_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  input  logic [15:0]             cmd_data,
  output logic                    cmd_ready,
  output logic [COMPARE_SIZE-1:0] compare_out,
  output logic [NUM_CH-1:0]       pwm_wr,
  output logic                    busy,
  output logic                    err
);

  // The address field is 4 bits and at most 8 channels exist, so 3 bits cover ch.
  localparam int unsigned ChW = 3;

  typedef enum logic [1:0] {StIdle, StScan, StWrite} state_e;

  state_e                  state_q;
  logic [ChW-1:0]          ch_q;
  logic                    pending_q;
  logic                    busy_q;
  logic                    err_q;
  logic                    ready_q;
  logic [COMPARE_SIZE-1:0] compare_q;
  logic [NUM_CH-1:0]       pwm_wr_q;

  logic [COMPARE_SIZE-1:0] current_q [NUM_CH];
  logic [COMPARE_SIZE-1:0] target_q  [NUM_CH];
  logic [COMPARE_SIZE-1:0] step_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] cnt_q;

  logic [3:0]  cmd_addr;
  logic [11:0] cmd_payload;
  logic        wr_target;
  logic        wr_step;
  logic        wr_period;
  logic        cmd_bad;
  logic        tick;

  logic [COMPARE_SIZE-1:0] cur_val;
  logic [COMPARE_SIZE-1:0] tgt_val;
  logic [COMPARE_SIZE-1:0] diff;
  logic [COMPARE_SIZE-1:0] next_val;
  logic                    last_ch;

  assign cmd_addr    = cmd_data[15:12];
  assign cmd_payload = cmd_data[11:0];
  assign tick        = (cnt_q == period_q);
  assign last_ch     = (ch_q == ChW'(NUM_CH - 1));

  // Command address decode; 0x8 belongs to the clock divider and is silently ignored.
  always_comb begin
    wr_target = 1'b0;
    wr_step   = 1'b0;
    wr_period = 1'b0;
    cmd_bad   = 1'b0;
    if (cmd_valid) begin
      if (32'(cmd_addr) < NUM_CH) begin
        wr_target = 1'b1;
      end else if (cmd_addr == 4'h9) begin
        wr_step = 1'b1;
      end else if (cmd_addr == 4'hA) begin
        wr_period = 1'b1;
      end else if (cmd_addr != 4'h8) begin
        cmd_bad = 1'b1;
      end
    end
  end

  // Next compare value: one step toward the target, landing exactly on it when close.
  always_comb begin
    cur_val  = current_q[ch_q];
    tgt_val  = target_q[ch_q];
    diff     = (tgt_val > cur_val) ? (tgt_val - cur_val) : (cur_val - tgt_val);
    next_val = tgt_val;
    if (step_q != '0 && step_q < diff) begin
      next_val = (tgt_val > cur_val) ? (cur_val + step_q) : (cur_val - step_q);
    end
  end

  // Configuration registers written by commands, plus the error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= '0;
      end
      step_q   <= COMPARE_SIZE'(1);
      period_q <= PERIOD_WIDTH'(255);
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      if (wr_target) begin
        target_q[cmd_addr[ChW-1:0]] <= cmd_payload[COMPARE_SIZE-1:0];
      end
      if (wr_step) begin
        step_q <= cmd_payload[COMPARE_SIZE-1:0];
      end
      if (wr_period) begin
        period_q <= cmd_payload[PERIOD_WIDTH-1:0];
      end
      err_q   <= cmd_bad;
      ready_q <= 1'b1;
    end
  end

  // Ramp tick counter; a period write restarts the count from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (wr_period || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PERIOD_WIDTH'(1);
    end
  end

  // Scan FSM: visits every channel, spends an extra write cycle on changed ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      compare_q <= '0;
      pwm_wr_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        current_q[i] <= '0;
      end
    end else begin
      pwm_wr_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (tick || pending_q) begin
            state_q   <= StScan;
            ch_q      <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StScan: begin
          if (tick) begin
            pending_q <= 1'b1;
          end
          if (cur_val != tgt_val) begin
            compare_q       <= next_val;
            pwm_wr_q        <= NUM_CH'(1) << ch_q;
            current_q[ch_q] <= next_val;
            state_q         <= StWrite;
          end else if (last_ch) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            ch_q <= ch_q + ChW'(1);
          end
        end
        StWrite: begin
          if (tick) begin
            pending_q <= 1'b1;
          end
          if (last_ch) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StScan;
            ch_q    <= ch_q + ChW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = ready_q;
  assign compare_out = compare_q;
  assign pwm_wr      = pwm_wr_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule
